// File: rtl/fsm_1.sv
// Moore detector for the serial pattern 1-0-1-1 (first bit first), with optional overlap.
// Define FSM_1_STATE_OUT_EN to expose the state and next_state debug ports.
module fsm_1 #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
`ifdef FSM_1_STATE_OUT_EN
    output logic [2:0] state,
    output logic [2:0] next_state,
`endif
    output logic       y
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S1 : S2;
            S2:      state_d = x ? S3 : S0;
            S3:      state_d = x ? S4 : S2;
            // A trailing "10" after a match is a prefix of the next one only when overlapping.
            S4:      state_d = x ? S1 : (OVERLAP ? S2 : S0);
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S0;
        else      state_q <= state_d;
    end

    assign y = (state_q == S4);

`ifdef FSM_1_STATE_OUT_EN
    assign state      = state_q;
    assign next_state = state_d;
`endif

endmodule

// File: tb/tb_fsm_1.sv
// Directed bench for fsm_1: runs overlapping and non-overlapping instances side by side.
module tb_fsm_1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x   = 1'b1;
    logic y_ov, y_nov;
`ifdef FSM_1_STATE_OUT_EN
    logic [2:0] st_ov, nst_ov, st_nov, nst_nov;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsm_1 #(.OVERLAP(1'b1)) u_ov (
        .clk(clk), .rst(rst), .x(x),
`ifdef FSM_1_STATE_OUT_EN
        .state(st_ov), .next_state(nst_ov),
`endif
        .y(y_ov)
    );

    fsm_1 #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .x(x),
`ifdef FSM_1_STATE_OUT_EN
        .state(st_nov), .next_state(nst_nov),
`endif
        .y(y_nov)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick(input logic xv);
        x = xv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst(input string tag, input int edges);
        rst = 1'b0;
        x   = 1'b1;
        repeat (edges) @(posedge clk);
        #1;
        chk({tag, ".y_ov"},  int'(y_ov),  0);
        chk({tag, ".y_nov"}, int'(y_nov), 0);
`ifdef FSM_1_STATE_OUT_EN
        chk({tag, ".st_ov"},  int'(st_ov),  0);
        chk({tag, ".st_nov"}, int'(st_nov), 0);
`endif
        rst = 1'b1;
    endtask

    // bits/eo/en are MSB-first: bit n-1 is the first sample, eo/en give y after each sample.
    task automatic run(input string tag, input int n, input logic [31:0] bits,
                       input logic [31:0] eo, input logic [31:0] en);
        for (int i = 0; i < n; i++) begin
            tick(bits[n-1-i]);
            chk($sformatf("%s.ov[%0d]", tag, i+1),  int'(y_ov),  int'(eo[n-1-i]));
            chk($sformatf("%s.nov[%0d]", tag, i+1), int'(y_nov), int'(en[n-1-i]));
        end
    endtask

    initial begin
        do_rst("reset", 2);
        tick(1'b1);
        chk("post_rst.y_ov",  int'(y_ov),  0);
        chk("post_rst.y_nov", int'(y_nov), 0);

        do_rst("r1", 1);
        run("basic", 4, 32'b1011, 32'b0001, 32'b0001);

        do_rst("r2", 1);
        run("overlap", 7, 32'b1011011, 32'b0001001, 32'b0001000);

        do_rst("r3", 1);
        run("mid", 3, 32'b101, 32'b000, 32'b000);
        do_rst("mid_rst", 1);
        tick(1'b1);
        chk("mid_after.y_ov",  int'(y_ov),  0);
        chk("mid_after.y_nov", int'(y_nov), 0);
`ifdef FSM_1_STATE_OUT_EN
        chk("mid_after.st_ov", int'(st_ov), 1);
`endif

        do_rst("r4", 1);
        run("held", 8, 32'b11001111, 32'b0, 32'b0);

        do_rst("r5", 1);
        run("long", 32, 32'hFFFF_0000, 32'b0, 32'b0);

        // Overlapping pulses land after bits 4, 10, 13, 16; non-overlapping after 4, 10, 16.
        do_rst("r6", 1);
        run("stream16", 16, 32'b1011_0010_1101_1011,
            32'b0001_0000_0100_1001, 32'b0001_0000_0100_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
